pe_array_1d_seq: RTL and testbench

Sequencer for the 1-D FP16 PE array. On `start` it validates the convolution config and loads up to five filter weights from the weight buffer into the array's B inputs. It then streams one activation row from the activation buffer into the array's A input, one sample per cycle. Using a tag pipeline, it captures each valid window result from the array output and emits it with its output index.

---
 rtl/pe_array_pkg.sv | 22 ++
 rtl/pe_tag_pipe.sv | 27 ++
 rtl/pe_array_1d_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_pe_array_1d_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared types and constants for the 1-D FP16 PE array sequencer.
package pe_array_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  localparam logic [2:0]  MAX_FILTER = 3'd5;
  localparam logic [2:0]  MAX_STRIDE = 3'd5;

  localparam logic [15:0] FP16_ZERO  = 16'h0000;
  localparam logic [15:0] FP16_ONE   = 16'h3C00;

  // True when a 3-bit config field lies in 1..max_v.
  function automatic logic range_ok(input logic [2:0] v, input logic [2:0] max_v);
    return (v != 3'd0) && (v <= max_v);
  endfunction

endpackage

// File: rtl/pe_tag_pipe.sv
// Shift register that delays the window-end flag so it lines up with
// the matching result leaving the PE array.
module pe_tag_pipe #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic tag_in,
  output logic tag_out,
  output logic empty
);

  logic [DEPTH-1:0] tags;

  // Shift one stage per cycle; reset empties the whole pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      tags <= '0;
    end else begin
      tags <= {tags[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = tags[DEPTH-1];
  assign empty   = ~|tags;

endmodule

// File: rtl/pe_array_1d_seq.sv
// Sequencer for the 1-D FP16 PE array: validates the config, loads the
// filter weights, streams one activation row and collects window results.
module pe_array_1d_seq
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int PE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            cfg_filter_size,
  input  logic [2:0]            cfg_stride,
  input  logic [LEN_W-1:0]      cfg_in_len,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  w_rd_en,
  output logic [2:0]            w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  a_rd_en,
  output logic [LEN_W-1:0]      a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data,
  output logic [2:0]            pe_filter_size,
  output logic [2:0]            pe_stride,
  output logic                  pe_clear,
  output logic [DATA_WIDTH-1:0] pe_current_a,
  output logic [DATA_WIDTH-1:0] pe_current_b1,
  output logic [DATA_WIDTH-1:0] pe_current_b2,
  output logic [DATA_WIDTH-1:0] pe_current_b3,
  output logic [DATA_WIDTH-1:0] pe_current_b4,
  output logic [DATA_WIDTH-1:0] pe_current_b5,
  input  logic [DATA_WIDTH-1:0] pe_array_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LEN_W-1:0]      out_idx
);

  localparam int TAG_DEPTH = 2 + PE_LATENCY;
  localparam logic [DATA_WIDTH-1:0] ZERO_W = DATA_WIDTH'(FP16_ZERO);

  seq_state_t       state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       w_cnt;
  logic             w_pend;
  logic [2:0]       w_pend_addr;
  logic [LEN_W-1:0] a_cnt;
  logic             a_pend;
  logic [2:0]       stride_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic             cfg_ok;
  logic             accept;
  logic             reject;
  logic             tag_in;
  logic             tag_out;
  logic             pipe_empty;
  logic             finish;
  logic             past_first_window;
  logic [LEN_W-1:0] fs_ext;
  logic [LEN_W-1:0] fs_m1_ext;

  assign fs_ext    = LEN_W'(cfg_filter_size);
  assign fs_m1_ext = LEN_W'(pe_filter_size - 3'd1);
  assign cfg_ok    = range_ok(cfg_filter_size, MAX_FILTER) &&
                     range_ok(cfg_stride, MAX_STRIDE) &&
                     (cfg_in_len >= fs_ext);
  assign past_first_window = (a_cnt >= fs_m1_ext);
  assign finish    = (state == DRAIN) && pipe_empty;

  // Next-state logic plus the buffer read strobes and window-end tag.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    reject    = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = 3'd0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    tag_in    = 1'b0;
    pe_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        pe_clear = 1'b1;
        if (start) begin
          if (cfg_ok) begin
            accept   = 1'b1;
            state_nx = LOAD_W;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LOAD_W: begin
        pe_clear = 1'b1;
        if (w_cnt < pe_filter_size) begin
          w_rd_en   = 1'b1;
          w_rd_addr = w_cnt;
        end
        if (w_pend && (w_pend_addr == (pe_filter_size - 3'd1))) begin
          state_nx = STREAM;
        end
      end
      STREAM: begin
        a_rd_en   = 1'b1;
        a_rd_addr = a_cnt;
        tag_in    = past_first_window && (stride_cnt == 3'd0);
        if (a_cnt == (len_q - LEN_W'(1))) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, config latch and the busy/done/cfg_err handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
      pe_filter_size <= 3'd0;
      pe_stride      <= 3'd0;
      len_q          <= '0;
    end else begin
      state   <= state_nx;
      cfg_err <= reject;
      done    <= finish;
      if (accept) begin
        pe_filter_size <= cfg_filter_size;
        pe_stride      <= cfg_stride;
        len_q          <= cfg_in_len;
        busy           <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

  // Weight load: track issued reads and write returning data one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_cnt         <= 3'd0;
      w_pend        <= 1'b0;
      w_pend_addr   <= 3'd0;
      pe_current_b1 <= ZERO_W;
      pe_current_b2 <= ZERO_W;
      pe_current_b3 <= ZERO_W;
      pe_current_b4 <= ZERO_W;
      pe_current_b5 <= ZERO_W;
    end else begin
      w_pend      <= w_rd_en;
      w_pend_addr <= w_rd_addr;
      if (accept) begin
        w_cnt         <= 3'd0;
        pe_current_b1 <= ZERO_W;
        pe_current_b2 <= ZERO_W;
        pe_current_b3 <= ZERO_W;
        pe_current_b4 <= ZERO_W;
        pe_current_b5 <= ZERO_W;
      end else begin
        if (w_rd_en) begin
          w_cnt <= w_cnt + 3'd1;
        end
        if (w_pend) begin
          unique case (w_pend_addr)
            3'd0:    pe_current_b1 <= w_rd_data;
            3'd1:    pe_current_b2 <= w_rd_data;
            3'd2:    pe_current_b3 <= w_rd_data;
            3'd3:    pe_current_b4 <= w_rd_data;
            default: pe_current_b5 <= w_rd_data;
          endcase
        end
      end
    end
  end

  // Activation stream: address counter, stride down-counter, sample register.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt        <= '0;
      a_pend       <= 1'b0;
      stride_cnt   <= 3'd0;
      pe_current_a <= ZERO_W;
    end else begin
      a_pend <= a_rd_en;
      if (accept) begin
        a_cnt        <= '0;
        stride_cnt   <= 3'd0;
        pe_current_a <= ZERO_W;
      end else begin
        if (a_rd_en) begin
          a_cnt <= a_cnt + LEN_W'(1);
          if (past_first_window) begin
            stride_cnt <= (stride_cnt == 3'd0) ? (pe_stride - 3'd1)
                                               : (stride_cnt - 3'd1);
          end
        end
        if (a_pend) begin
          pe_current_a <= a_rd_data;
        end
      end
    end
  end

  // Capture the array result whenever a delayed window-end tag emerges.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= ZERO_W;
      out_idx   <= '0;
      out_cnt   <= '0;
    end else begin
      out_valid <= tag_out;
      if (accept) begin
        out_cnt <= '0;
      end else if (tag_out) begin
        out_data <= pe_array_out;
        out_idx  <= out_cnt;
        out_cnt  <= out_cnt + LEN_W'(1);
      end
    end
  end

  pe_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .empty   (pipe_empty)
  );

endmodule

// File: tb/tb_pe_array_1d_seq.sv
// Self-checking bench for pe_array_1d_seq with a behavioural FP16 PE array.
module tb_pe_array_1d_seq;
  import pe_array_pkg::*;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int PL = 4;

  typedef struct {
    logic [2:0]  fs;
    logic [2:0]  st;
    logic [7:0]  len;
    logic [15:0] w;
    int          nexp;
  } vec_t;

  typedef struct {
    logic [2:0] fs;
    logic [2:0] st;
    logic [7:0] len;
  } bad_t;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    cfg_filter_size;
  logic [2:0]    cfg_stride;
  logic [LW-1:0] cfg_in_len;
  logic          busy, done, cfg_err;
  logic          w_rd_en;
  logic [2:0]    w_rd_addr;
  logic [DW-1:0] w_rd_data;
  logic          a_rd_en;
  logic [LW-1:0] a_rd_addr;
  logic [DW-1:0] a_rd_data;
  logic [2:0]    pe_filter_size, pe_stride;
  logic          pe_clear;
  logic [DW-1:0] pe_current_a;
  logic [DW-1:0] pe_current_b1, pe_current_b2, pe_current_b3, pe_current_b4, pe_current_b5;
  logic [DW-1:0] pe_array_out;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_idx;

  logic [15:0] wmem [0:7];
  logic [15:0] amem [0:255];
  logic [15:0] hist [0:3];
  logic [15:0] dly  [0:3];

  exp_t sb[$];
  vec_t vecs[4];
  bad_t bads[3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_pulses = 0;
  int done_total = 0;
  int cfg_err_total = 0;
  int w_reads = 0;
  int a_reads = 0;
  int last_out_cyc = 0;

  always #5 clk = ~clk;

  pe_array_1d_seq #(
    .DATA_WIDTH (DW),
    .LEN_W      (LW),
    .PE_LATENCY (PL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_filter_size (cfg_filter_size),
    .cfg_stride      (cfg_stride),
    .cfg_in_len      (cfg_in_len),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .w_rd_en         (w_rd_en),
    .w_rd_addr       (w_rd_addr),
    .w_rd_data       (w_rd_data),
    .a_rd_en         (a_rd_en),
    .a_rd_addr       (a_rd_addr),
    .a_rd_data       (a_rd_data),
    .pe_filter_size  (pe_filter_size),
    .pe_stride       (pe_stride),
    .pe_clear        (pe_clear),
    .pe_current_a    (pe_current_a),
    .pe_current_b1   (pe_current_b1),
    .pe_current_b2   (pe_current_b2),
    .pe_current_b3   (pe_current_b3),
    .pe_current_b4   (pe_current_b4),
    .pe_current_b5   (pe_current_b5),
    .pe_array_out    (pe_array_out),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_idx         (out_idx)
  );

  // FP16 (normal numbers and zero only) to real.
  function automatic real fp16_to_real(input logic [15:0] h);
    int  e;
    real r;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(int'(h[9:0])) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -r : r;
  endfunction

  // Real to FP16 with round-to-nearest on the mantissa.
  function automatic logic [15:0] real_to_fp16(input real r);
    logic s;
    int   e;
    int   man;
    real  a;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    man = int'((a - 1.0) * 1024.0);
    if (man == 1024) begin man = 0; e++; end
    return {s, 5'(e + 15), 10'(man)};
  endfunction

  // Dot product of the newest fs samples with weights b1..bfs, oldest sample first.
  function automatic logic [15:0] window_dot(
    input logic [15:0] s0, s1, s2, s3, s4,
    input logic [15:0] c1, c2, c3, c4, c5,
    input logic [2:0]  fs);
    logic [15:0] s [5];
    logic [15:0] c [5];
    real acc;
    s = '{s0, s1, s2, s3, s4};
    c = '{c1, c2, c3, c4, c5};
    acc = 0.0;
    for (int k = 0; k < 5; k++) begin
      if (k < int'(fs)) acc += fp16_to_real(c[k]) * fp16_to_real(s[int'(fs) - 1 - k]);
    end
    return real_to_fp16(acc);
  endfunction

  // Weight and activation buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
  end

  // Behavioural PE array: result for the window ending on a sample shows up PL cycles later.
  always @(posedge clk) begin
    hist[0] <= pe_current_a;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    hist[3] <= hist[2];
    dly[0]  <= window_dot(pe_current_a, hist[0], hist[1], hist[2], hist[3],
                          pe_current_b1, pe_current_b2, pe_current_b3,
                          pe_current_b4, pe_current_b5, pe_filter_size);
    dly[1]  <= dly[0];
    dly[2]  <= dly[1];
    dly[3]  <= dly[2];
  end
  assign pe_array_out = dly[3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: counts strobes and checks each result against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (w_rd_en) w_reads++;
      if (a_rd_en) a_reads++;
      if (done)    done_total++;
      if (cfg_err) cfg_err_total++;
      if (out_valid) begin
        out_pulses++;
        last_out_cyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_idx",  32'(out_idx),  32'(e.idx));
        end
      end
    end
  end

  task automatic loadBuffers(input vec_t v);
    for (int k = 0; k < 8; k++)   wmem[k] = (k < int'(v.fs)) ? v.w : 16'h5555;
    for (int k = 0; k < 256; k++) amem[k] = real_to_fp16(real'(k + 1));
  endtask

  // Runs one legal configuration; optionally pulses start during LOAD_W and DRAIN.
  task automatic applyStimulus(input vec_t v, input bit inject, input int id);
    int  w0, a0, ce0, done_cyc;
    bit  got, inj_l, inj_d, seen_a;
    real acc;
    logic [15:0] bv [5];
    loadBuffers(v);
    for (int j = 0; j < v.nexp; j++) begin
      acc = 0.0;
      for (int k = 0; k < int'(v.fs); k++)
        acc += fp16_to_real(v.w) * real'(j * int'(v.st) + k + 1);
      sb.push_back('{8'(j), real_to_fp16(acc)});
    end
    w0 = w_reads; a0 = a_reads; ce0 = cfg_err_total; out_pulses = 0;
    @(negedge clk);
    start = 1'b1; cfg_filter_size = v.fs; cfg_stride = v.st; cfg_in_len = v.len;
    @(negedge clk);
    start = 1'b0;
    got = 0; inj_l = 0; inj_d = 0; seen_a = 0; done_cyc = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1;
        done_cyc = cyc;
      end else if (inject) begin
        if (a_rd_en) seen_a = 1;
        if (!inj_l && w_rd_en) begin
          start = 1'b1; cfg_filter_size = 3'd0; inj_l = 1;
        end else if (!inj_d && seen_a && !a_rd_en && busy) begin
          start = 1'b1; cfg_filter_size = 3'd2; cfg_stride = 3'd1; cfg_in_len = 8'd4; inj_d = 1;
        end
      end
    end
    start = 1'b0;
    checkOutput($sformatf("c%0d_done_seen", id), 32'(got), 32'd1);
    checkOutput($sformatf("c%0d_out_count", id), 32'(out_pulses), 32'(v.nexp));
    if (got) checkOutput($sformatf("c%0d_done_gap", id), 32'(done_cyc - last_out_cyc), 32'd1);
    checkOutput($sformatf("c%0d_w_reads", id), 32'(w_reads - w0), 32'(v.fs));
    checkOutput($sformatf("c%0d_a_reads", id), 32'(a_reads - a0), 32'(v.len));
    checkOutput($sformatf("c%0d_sb_left", id), 32'(sb.size()), 32'd0);
    sb.delete();
    bv = '{pe_current_b1, pe_current_b2, pe_current_b3, pe_current_b4, pe_current_b5};
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("c%0d_b%0d", id, k + 1), 32'(bv[k]),
                  (k < int'(v.fs)) ? 32'(v.w) : 32'd0);
    if (inject) checkOutput($sformatf("c%0d_no_cfg_err", id), 32'(cfg_err_total - ce0), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("c%0d_idle_after", id), {29'd0, busy, done, w_rd_en}, 32'd0);
  endtask

  // Rejected configuration: one cfg_err pulse, no busy, no buffer reads.
  task automatic applyIllegal(input bad_t b, input int id);
    int r0;
    r0 = w_reads + a_reads;
    @(negedge clk);
    start = 1'b1; cfg_filter_size = b.fs; cfg_stride = b.st; cfg_in_len = b.len;
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("bad%0d_err_pulse", id), {30'd0, cfg_err, busy}, 32'd2);
    @(negedge clk);
    checkOutput($sformatf("bad%0d_err_clear", id), {30'd0, cfg_err, busy}, 32'd0);
    checkOutput($sformatf("bad%0d_no_reads", id), 32'(w_reads + a_reads - r0), 32'd0);
  endtask

  initial begin
    vec_t mid;
    int   d0, seen;
    vecs[0] = '{3'd1, 3'd1, 8'd4,  16'hC000, 4};
    vecs[1] = '{3'd3, 3'd1, 8'd5,  16'h3C00, 3};
    vecs[2] = '{3'd3, 3'd2, 8'd8,  16'h3C00, 3};
    vecs[3] = '{3'd5, 3'd3, 8'd12, 16'h3C00, 3};
    bads[0] = '{3'd0, 3'd1, 8'd4};
    bads[1] = '{3'd1, 3'd6, 8'd4};
    bads[2] = '{3'd4, 3'd1, 8'd3};

    reset = 1'b1; start = 1'b0;
    cfg_filter_size = 3'd0; cfg_stride = 3'd0; cfg_in_len = '0;
    repeat (2) @(negedge clk);
    start = 1'b1; cfg_filter_size = 3'd3; cfg_stride = 3'd1; cfg_in_len = 8'd5;
    @(negedge clk);
    checkOutput("rst_ctrl", {26'd0, busy, done, cfg_err, w_rd_en, a_rd_en, out_valid}, 32'd0);
    checkOutput("rst_clear", 32'(pe_clear), 32'd1);
    checkOutput("rst_a", 32'(pe_current_a), 32'd0);
    checkOutput("rst_b", 32'(pe_current_b1 | pe_current_b2 | pe_current_b3 | pe_current_b4 | pe_current_b5), 32'd0);
    checkOutput("rst_cfg", {26'd0, pe_filter_size, pe_stride}, 32'd0);
    checkOutput("rst_out", {8'd0, out_data, out_idx}, 32'd0);
    checkOutput("rst_addr", {21'd0, w_rd_addr, a_rd_addr}, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("start_in_reset_ignored", {30'd0, busy, w_rd_en}, 32'd0);

    $display("[TB] legal configurations");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b0, i);

    $display("[TB] illegal configurations");
    for (int i = 0; i < 3; i++) applyIllegal(bads[i], i);

    $display("[TB] reset during STREAM");
    mid = '{3'd3, 3'd1, 8'd20, 16'h3C00, 0};
    loadBuffers(mid);
    out_pulses = 0;
    @(negedge clk);
    start = 1'b1; cfg_filter_size = mid.fs; cfg_stride = mid.st; cfg_in_len = mid.len;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen < 2; c++) begin
      @(negedge clk);
      if (a_rd_en) seen++;
    end
    checkOutput("mid_stream_reached", 32'(seen), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ctrl", {26'd0, busy, done, cfg_err, w_rd_en, a_rd_en, out_valid}, 32'd0);
    checkOutput("mid_rst_clear_a", {15'd0, pe_clear, pe_current_a}, 32'h0001_0000);
    checkOutput("mid_rst_cfg_addr", {18'd0, pe_filter_size, pe_stride, a_rd_addr}, 32'd0);
    reset = 1'b0;
    d0 = done_total;
    repeat (15) @(negedge clk);
    checkOutput("mid_no_done", 32'(done_total - d0), 32'd0);
    checkOutput("mid_no_out", 32'(out_pulses), 32'd0);
    applyStimulus(vecs[1], 1'b0, 10);

    $display("[TB] start pulses while busy");
    applyStimulus(vecs[1], 1'b1, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
